// File: rtl/dfe_pkg.sv
// dfe_pkg: shared definitions for the DFE configuration sequencer.
//   - dfe_state_e    : sequencer state encoding
//   - DEC_W / CNT_W  : decimation-factor and event-counter widths
//   - DEC_*          : legal CIC decimation factors
//   - is_legal_factor: returns 1 for a supported CIC decimation factor
package dfe_pkg;

  localparam int unsigned DEC_W = 5;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_RUN      = 2'd2,
    ST_WAIT_BND = 2'd3
  } dfe_state_e;

  localparam logic [DEC_W-1:0] DEC_1  = 5'd1;
  localparam logic [DEC_W-1:0] DEC_2  = 5'd2;
  localparam logic [DEC_W-1:0] DEC_4  = 5'd4;
  localparam logic [DEC_W-1:0] DEC_8  = 5'd8;
  localparam logic [DEC_W-1:0] DEC_16 = 5'd16;

  function automatic logic is_legal_factor(input logic [DEC_W-1:0] f);
    return (f == DEC_1) || (f == DEC_2) || (f == DEC_4) ||
           (f == DEC_8) || (f == DEC_16);
  endfunction

endpackage

// File: rtl/dfe_evt_counter.sv
// dfe_evt_counter: saturating down-counter with synchronous load.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (count <= RST_VAL)
//   load_i     in   load load_val_i (has priority over decrement)
//   load_val_i in   value to load
//   dec_i      in   decrement enable; holds at zero instead of wrapping
//   count_o    out  current count
module dfe_evt_counter #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/dfe_cfg_ctrl.sv
// dfe_cfg_ctrl: configuration sequencer for the DFE receive chain.
// Accepts CIC decimation-factor / filter-enable requests, rejects illegal
// factors, applies legal changes at a CIC output boundary, then flushes the
// datapath and masks output strobes until the pipeline has refilled.
// Ports:
//   CLK                   in   chain clock
//   RST                   in   asynchronous active-low reset
//   cfg_valid             in   request valid
//   cfg_ready             out  request can be accepted (RUN only)
//   cfg_dec_factor        in   requested CIC factor
//   cfg_filter_enable     in   requested filter enable
//   cic_out_strobe        in   one-clock pulse per CIC output sample
//   CIC_Decimation_Factor out  applied factor
//   filter_enable         out  applied enable
//   datapath_clr          out  synchronous clear to FD/notch/CIC
//   out_valid             out  qualified output strobe
//   busy                  out  reconfiguration in progress
//   cfg_done              out  one-clock pulse on request completion
//   cfg_error             out  one-clock pulse on request rejection
module dfe_cfg_ctrl
  import dfe_pkg::*;
#(
  parameter int unsigned DEFAULT_DEC    = 8,
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned SETTLE_SAMPLES = 2,
  parameter int unsigned WAIT_TIMEOUT   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DEC_W-1:0] cfg_dec_factor,
  input  logic             cfg_filter_enable,
  input  logic             cic_out_strobe,
  output logic [DEC_W-1:0] CIC_Decimation_Factor,
  output logic             filter_enable,
  output logic             datapath_clr,
  output logic             out_valid,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_error
);

  localparam logic [DEC_W-1:0] DEF_DEC   = DEC_W'(DEFAULT_DEC);
  localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(WAIT_TIMEOUT);

  dfe_state_e       state_q, state_d;
  logic [DEC_W-1:0] fac_q, fac_d;
  logic             en_q, en_d;
  logic [DEC_W-1:0] pend_fac_q, pend_fac_d;
  logic             pend_en_q, pend_en_d;
  logic             boot_q, boot_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clr_q;
  logic             busy_q;

  logic             flush_ld, flush_dec;
  logic             settle_ld, settle_dec;
  logic             tmo_ld, tmo_dec;
  logic [CNT_W-1:0] flush_cnt, settle_cnt, tmo_cnt;

  // Flush counter comes out of reset preloaded so the boot flush needs no
  // separate load path.
  dfe_evt_counter #(.WIDTH(CNT_W), .RST_VAL(FLUSH_LD)) u_flush_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load_i     (flush_ld),
    .load_val_i (FLUSH_LD),
    .dec_i      (flush_dec),
    .count_o    (flush_cnt)
  );

  dfe_evt_counter #(.WIDTH(CNT_W), .RST_VAL(SETTLE_LD)) u_settle_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load_i     (settle_ld),
    .load_val_i (SETTLE_LD),
    .dec_i      (settle_dec),
    .count_o    (settle_cnt)
  );

  dfe_evt_counter #(.WIDTH(CNT_W), .RST_VAL(TMO_LD)) u_tmo_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load_i     (tmo_ld),
    .load_val_i (TMO_LD),
    .dec_i      (tmo_dec),
    .count_o    (tmo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    fac_d      = fac_q;
    en_d       = en_q;
    pend_fac_d = pend_fac_q;
    pend_en_d  = pend_en_q;
    boot_d     = boot_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    flush_ld   = 1'b0;
    flush_dec  = 1'b0;
    settle_ld  = 1'b0;
    settle_dec = 1'b0;
    tmo_ld     = 1'b0;
    tmo_dec    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (cfg_valid) begin
          if (!is_legal_factor(cfg_dec_factor)) begin
            err_d = 1'b1;
          end else if ((cfg_dec_factor == fac_q) && (cfg_filter_enable == en_q)) begin
            done_d = 1'b1;
          end else begin
            pend_fac_d = cfg_dec_factor;
            pend_en_d  = cfg_filter_enable;
            tmo_ld     = 1'b1;
            state_d    = ST_WAIT_BND;
          end
        end
      end

      ST_WAIT_BND: begin
        tmo_dec = 1'b1;
        // Timeout counter is loaded with WAIT_TIMEOUT; seeing 1 here means
        // this is the WAIT_TIMEOUT-th clock spent waiting.
        if (!en_q || cic_out_strobe || (tmo_cnt <= CNT_W'(1))) begin
          fac_d    = pend_fac_q;
          en_d     = pend_en_q;
          flush_ld = 1'b1;
          state_d  = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        flush_dec = 1'b1;
        if (flush_cnt <= CNT_W'(1)) begin
          if (!en_q) begin
            state_d = ST_RUN;
            done_d  = !boot_q;
            boot_d  = 1'b0;
          end else begin
            settle_ld = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        settle_dec = cic_out_strobe;
        if ((settle_cnt == '0) || (cic_out_strobe && (settle_cnt == CNT_W'(1)))) begin
          state_d = ST_RUN;
          done_d  = !boot_q;
          boot_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_FLUSH;
      fac_q      <= DEF_DEC;
      en_q       <= 1'b1;
      pend_fac_q <= DEF_DEC;
      pend_en_q  <= 1'b1;
      boot_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fac_q      <= fac_d;
      en_q       <= en_d;
      pend_fac_q <= pend_fac_d;
      pend_en_q  <= pend_en_d;
      boot_q     <= boot_d;
      done_q     <= done_d;
      err_q      <= err_d;
      // Registered from next state so they track the state register exactly.
      clr_q      <= (state_d == ST_FLUSH);
      busy_q     <= (state_d != ST_RUN);
    end
  end

  assign CIC_Decimation_Factor = fac_q;
  assign filter_enable         = en_q;
  assign datapath_clr          = clr_q;
  assign busy                  = busy_q;
  assign cfg_done              = done_q;
  assign cfg_error             = err_q;
  assign cfg_ready             = (state_q == ST_RUN);
  assign out_valid             = cic_out_strobe & en_q &
                                 ((state_q == ST_RUN) | (state_q == ST_WAIT_BND));

endmodule
